// File: rtl/piksel_paketleyici.sv
// Packs decoded pixels into bus words, counts pixels per frame, zero-pads and flags the last word.
// Define PAKET_BIG_ENDIAN_EN to place the first pixel of a word in the top lane.
module piksel_paketleyici #(
  parameter int PIXEL_BIT  = 8,
  parameter int WB_BIT     = 32,
  parameter int IMG_PIXELS = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PIXEL_BIT-1:0] pix_veri_i,
  input  logic                 pix_gecerli_i,
  output logic                 pix_hazir_o,
  output logic [WB_BIT-1:0]    paket_veri_o,
  output logic                 paket_gecerli_o,
  output logic                 paket_son_o,
  input  logic                 paket_hazir_i,
  output logic                 cerceve_bitti_o
);

  localparam int unsigned LANES = WB_BIT / PIXEL_BIT;
  localparam int          LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int          CW    = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [CW-1:0] PIX_LAST  = CW'(IMG_PIXELS - 1);

  logic              rdy_q;
  logic [LW-1:0]     lane_q, lane_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WB_BIT-1:0] acc_q, acc_d;
  logic [WB_BIT-1:0] veri_q, veri_d;
  logic              gecerli_q, gecerli_d;
  logic              son_q, son_d;
  logic              bitti_q, bitti_d;

  logic              in_last;
  logic              word_end;
  logic              in_fire;
  logic              out_fire;
  logic [WB_BIT-1:0] slot;

  always_comb begin
    in_last  = (cnt_q == PIX_LAST);
    word_end = (lane_q == LANE_LAST) || in_last;
    // Only a word-completing pixel can be refused, and only while the output is stalled.
    pix_hazir_o = rdy_q && !(word_end && gecerli_q && !paket_hazir_i);
    in_fire  = pix_gecerli_i && pix_hazir_o;
    out_fire = gecerli_q && paket_hazir_i;

    slot = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
`ifdef PAKET_BIG_ENDIAN_EN
        slot[(LANES-1-k)*PIXEL_BIT +: PIXEL_BIT] = pix_veri_i;
`else
        slot[k*PIXEL_BIT +: PIXEL_BIT] = pix_veri_i;
`endif
      end
    end

    lane_d    = lane_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    veri_d    = veri_q;
    gecerli_d = gecerli_q;
    son_d     = son_q;
    bitti_d   = out_fire && son_q;

    if (out_fire) begin
      gecerli_d = 1'b0;
      son_d     = 1'b0;
    end

    // A completing word overrides the drain above, so valid stays high without a bubble.
    if (in_fire) begin
      cnt_d = in_last ? '0 : cnt_q + CW'(1);
      if (word_end) begin
        lane_d    = '0;
        acc_d     = '0;
        veri_d    = acc_q | slot;
        gecerli_d = 1'b1;
        son_d     = in_last;
      end else begin
        lane_d = lane_q + LW'(1);
        acc_d  = acc_q | slot;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_q     <= 1'b0;
      lane_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      veri_q    <= '0;
      gecerli_q <= 1'b0;
      son_q     <= 1'b0;
      bitti_q   <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      veri_q    <= veri_d;
      gecerli_q <= gecerli_d;
      son_q     <= son_d;
      bitti_q   <= bitti_d;
    end
  end

  assign paket_veri_o    = veri_q;
  assign paket_gecerli_o = gecerli_q;
  assign paket_son_o     = son_q;
  assign cerceve_bitti_o = bitti_q;

endmodule

// File: tb/tb_piksel_paketleyici.sv
// Directed bench for piksel_paketleyici: a default-size instance plus a 6-pixel-frame instance.
module tb_piksel_paketleyici;

`ifdef PAKET_BIG_ENDIAN_EN
  localparam logic [31:0] W_SINGLE = 32'h11223344;
  localparam logic [31:0] W_A      = 32'hA1A2A3A4;
  localparam logic [31:0] W_B      = 32'hB1B2B3B4;
  localparam logic [31:0] W_C      = 32'hC1C2C3C4;
  localparam logic [31:0] W_D      = 32'hD1D2D3D4;
  localparam logic [31:0] W_F      = 32'hF1F2F3F4;
  localparam logic [31:0] W_FR1    = 32'h01020304;
  localparam logic [31:0] W_FR2    = 32'h05060000;
  localparam logic [31:0] W_FR3    = 32'h0A0B0C0D;
`else
  localparam logic [31:0] W_SINGLE = 32'h44332211;
  localparam logic [31:0] W_A      = 32'hA4A3A2A1;
  localparam logic [31:0] W_B      = 32'hB4B3B2B1;
  localparam logic [31:0] W_C      = 32'hC4C3C2C1;
  localparam logic [31:0] W_D      = 32'hD4D3D2D1;
  localparam logic [31:0] W_F      = 32'hF4F3F2F1;
  localparam logic [31:0] W_FR1    = 32'h04030201;
  localparam logic [31:0] W_FR2    = 32'h00000605;
  localparam logic [31:0] W_FR3    = 32'h0D0C0B0A;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  px  = '0;
  logic        pv  = 1'b0;
  logic        hz  = 1'b0;
  logic        ph, pg, ps, bt;
  logic [31:0] pw;
  logic [7:0]  px6 = '0;
  logic        pv6 = 1'b0;
  logic        hz6 = 1'b0;
  logic        ph6, pg6, ps6, bt6;
  logic [31:0] pw6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piksel_paketleyici dut (
    .clk_i(clk), .rst_i(rst), .pix_veri_i(px), .pix_gecerli_i(pv), .pix_hazir_o(ph),
    .paket_veri_o(pw), .paket_gecerli_o(pg), .paket_son_o(ps), .paket_hazir_i(hz),
    .cerceve_bitti_o(bt)
  );

  piksel_paketleyici #(.PIXEL_BIT(8), .WB_BIT(32), .IMG_PIXELS(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .pix_veri_i(px6), .pix_gecerli_i(pv6), .pix_hazir_o(ph6),
    .paket_veri_o(pw6), .paket_gecerli_o(pg6), .paket_son_o(ps6), .paket_hazir_i(hz6),
    .cerceve_bitti_o(bt6)
  );

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    #2 rst = 1'b1;
    #1;
    checks++; if (ph !== 1'b0) begin failures++; $display("FAIL rst_hazir got=%b exp=0", ph); end
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL rst_gecerli got=%b exp=0", pg); end
    checks++; if (ps !== 1'b0) begin failures++; $display("FAIL rst_son got=%b exp=0", ps); end
    checks++; if (pw !== 32'h0) begin failures++; $display("FAIL rst_veri got=%h exp=0", pw); end
    checks++; if (bt !== 1'b0) begin failures++; $display("FAIL rst_bitti got=%b exp=0", bt); end
    checks++; if (ph6 !== 1'b0) begin failures++; $display("FAIL rst_hazir6 got=%b exp=0", ph6); end
    cyc; cyc;
    rst = 1'b0;
    #1;
    checks++; if (ph !== 1'b0) begin failures++; $display("FAIL rst_release_hazir got=%b exp=0", ph); end
    cyc;
    checks++; if (ph !== 1'b1) begin failures++; $display("FAIL post_rst_hazir got=%b exp=1", ph); end
  endtask

  task test_single_word;
    hz = 1'b1; pv = 1'b1;
    px = 8'h11; cyc; px = 8'h22; cyc; px = 8'h33; cyc;
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", pg); end
    px = 8'h44; cyc; pv = 1'b0;
    checks++; if (pg !== 1'b1) begin failures++; $display("FAIL single_gecerli got=%b exp=1", pg); end
    checks++; if (pw !== W_SINGLE) begin failures++; $display("FAIL single_veri got=%h exp=%h", pw, W_SINGLE); end
    checks++; if (ps !== 1'b0) begin failures++; $display("FAIL single_son got=%b exp=0", ps); end
    cyc;
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", pg); end
    checks++; if (bt !== 1'b0) begin failures++; $display("FAIL single_bitti got=%b exp=0", bt); end
  endtask

  task test_frame;
    hz6 = 1'b1; pv6 = 1'b1;
    px6 = 8'h01; cyc; px6 = 8'h02; cyc; px6 = 8'h03; cyc; px6 = 8'h04; cyc;
    checks++; if (pg6 !== 1'b1) begin failures++; $display("FAIL frame_w1_gecerli got=%b exp=1", pg6); end
    checks++; if (pw6 !== W_FR1) begin failures++; $display("FAIL frame_w1_veri got=%h exp=%h", pw6, W_FR1); end
    checks++; if (ps6 !== 1'b0) begin failures++; $display("FAIL frame_w1_son got=%b exp=0", ps6); end
    px6 = 8'h05; cyc;
    checks++; if (pg6 !== 1'b0) begin failures++; $display("FAIL frame_gap got=%b exp=0", pg6); end
    checks++; if (ph6 !== 1'b1) begin failures++; $display("FAIL frame_last_hazir got=%b exp=1", ph6); end
    px6 = 8'h06; cyc; pv6 = 1'b0;
    checks++; if (pg6 !== 1'b1) begin failures++; $display("FAIL frame_w2_gecerli got=%b exp=1", pg6); end
    checks++; if (pw6 !== W_FR2) begin failures++; $display("FAIL frame_w2_veri got=%h exp=%h", pw6, W_FR2); end
    checks++; if (ps6 !== 1'b1) begin failures++; $display("FAIL frame_w2_son got=%b exp=1", ps6); end
    checks++; if (bt6 !== 1'b0) begin failures++; $display("FAIL frame_bitti_early got=%b exp=0", bt6); end
    cyc;
    checks++; if (pg6 !== 1'b0) begin failures++; $display("FAIL frame_w2_drain got=%b exp=0", pg6); end
    checks++; if (bt6 !== 1'b1) begin failures++; $display("FAIL frame_bitti got=%b exp=1", bt6); end
    cyc;
    checks++; if (bt6 !== 1'b0) begin failures++; $display("FAIL frame_bitti_width got=%b exp=0", bt6); end
    pv6 = 1'b1;
    px6 = 8'h0A; cyc; px6 = 8'h0B; cyc; px6 = 8'h0C; cyc; px6 = 8'h0D; cyc; pv6 = 1'b0;
    checks++; if (pg6 !== 1'b1) begin failures++; $display("FAIL wrap_gecerli got=%b exp=1", pg6); end
    checks++; if (pw6 !== W_FR3) begin failures++; $display("FAIL wrap_veri got=%h exp=%h", pw6, W_FR3); end
    checks++; if (ps6 !== 1'b0) begin failures++; $display("FAIL wrap_son got=%b exp=0", ps6); end
    cyc;
    checks++; if (pg6 !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b exp=0", pg6); end
    checks++; if (bt6 !== 1'b0) begin failures++; $display("FAIL wrap_bitti got=%b exp=0", bt6); end
  endtask

  task test_backpressure;
    hz = 1'b0; pv = 1'b1;
    px = 8'hA1; cyc; px = 8'hA2; cyc; px = 8'hA3; cyc; px = 8'hA4; cyc;
    checks++; if (pg !== 1'b1) begin failures++; $display("FAIL bp_a_gecerli got=%b exp=1", pg); end
    checks++; if (pw !== W_A) begin failures++; $display("FAIL bp_a_veri got=%h exp=%h", pw, W_A); end
    px = 8'hB1; #1;
    checks++; if (ph !== 1'b1) begin failures++; $display("FAIL bp_b1_hazir got=%b exp=1", ph); end
    cyc; px = 8'hB2; cyc; px = 8'hB3; cyc; px = 8'hB4; #1;
    checks++; if (ph !== 1'b0) begin failures++; $display("FAIL bp_b4_hazir got=%b exp=0", ph); end
    for (int i = 0; i < 3; i++) begin
      cyc;
      checks++; if (pw !== W_A) begin failures++; $display("FAIL bp_hold_veri got=%h exp=%h", pw, W_A); end
      checks++; if (pg !== 1'b1) begin failures++; $display("FAIL bp_hold_gecerli got=%b exp=1", pg); end
      checks++; if (ph !== 1'b0) begin failures++; $display("FAIL bp_hold_hazir got=%b exp=0", ph); end
    end
    hz = 1'b1; #1;
    checks++; if (ph !== 1'b1) begin failures++; $display("FAIL bp_release_hazir got=%b exp=1", ph); end
    cyc; pv = 1'b0;
    checks++; if (pg !== 1'b1) begin failures++; $display("FAIL bp_b_gecerli got=%b exp=1", pg); end
    checks++; if (pw !== W_B) begin failures++; $display("FAIL bp_b_veri got=%h exp=%h", pw, W_B); end
    cyc;
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL bp_b_drain got=%b exp=0", pg); end
  endtask

  task test_back_to_back;
    hz = 1'b1; pv = 1'b1;
    px = 8'hC1; cyc; px = 8'hC2; cyc; px = 8'hC3; cyc; px = 8'hC4; cyc;
    hz = 1'b0;
    checks++; if (pw !== W_C) begin failures++; $display("FAIL b2b_c_veri got=%h exp=%h", pw, W_C); end
    px = 8'hD1; cyc; px = 8'hD2; cyc; px = 8'hD3; cyc;
    checks++; if (pg !== 1'b1) begin failures++; $display("FAIL b2b_c_held got=%b exp=1", pg); end
    px = 8'hD4; hz = 1'b1; cyc; pv = 1'b0;
    checks++; if (pg !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%b exp=1", pg); end
    checks++; if (pw !== W_D) begin failures++; $display("FAIL b2b_d_veri got=%h exp=%h", pw, W_D); end
    cyc;
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL b2b_d_drain got=%b exp=0", pg); end
  endtask

  task test_mid_reset;
    hz = 1'b1; pv = 1'b1;
    px = 8'hE1; cyc; px = 8'hE2; cyc;
    rst = 1'b1; #1;
    checks++; if (ph !== 1'b0) begin failures++; $display("FAIL mrst_hazir got=%b exp=0", ph); end
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL mrst_gecerli got=%b exp=0", pg); end
    checks++; if (pw !== 32'h0) begin failures++; $display("FAIL mrst_veri got=%h exp=0", pw); end
    checks++; if (ps !== 1'b0) begin failures++; $display("FAIL mrst_son got=%b exp=0", ps); end
    pv = 1'b0;
    cyc; rst = 1'b0; cyc;
    pv = 1'b1;
    px = 8'hF1; cyc; px = 8'hF2; cyc; px = 8'hF3; cyc;
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL mrst_no_partial got=%b exp=0", pg); end
    px = 8'hF4; cyc; pv = 1'b0;
    checks++; if (pg !== 1'b1) begin failures++; $display("FAIL mrst_f_gecerli got=%b exp=1", pg); end
    checks++; if (pw !== W_F) begin failures++; $display("FAIL mrst_f_veri got=%h exp=%h", pw, W_F); end
    cyc;
    checks++; if (pg !== 1'b0) begin failures++; $display("FAIL mrst_f_drain got=%b exp=0", pg); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_word;
    test_frame;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
